// File: rtl/disp_addr_ctrl_if.sv
// Bus bundle for the encoder-driven display address controller:
// encoder phases, page/clear controls, and the address/pulse outputs.
interface disp_addr_ctrl_if;
  logic       rot_a;
  logic       rot_b;
  logic [1:0] page;
  logic       clr;
  logic [4:0] addr;
  logic [7:0] disp_addr;
  logic       step_inc;
  logic       step_dec;
  logic       quad_err;

  modport master (
    output rot_a, rot_b, page, clr,
    input  addr, disp_addr, step_inc, step_dec, quad_err
  );

  modport slave (
    input  rot_a, rot_b, page, clr,
    output addr, disp_addr, step_inc, step_dec, quad_err
  );
endinterface

// File: rtl/disp_addr_ctrl.sv
// Rotary-encoder address controller: synchronizes and decodes quadrature phases,
// accumulates DETENT transitions per step, and steps one of four page address registers.
module disp_addr_ctrl #(
  parameter int DETENT      = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  disp_addr_ctrl_if.slave bus
);

  localparam logic signed [3:0] DET_POS = 4'(DETENT);
  localparam logic signed [3:0] DET_NEG = -4'(DETENT);

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic [1:0]             phase_q, phase_d;
  logic [1:0]             cur_phase;
  logic signed [3:0]      acc_q, acc_d;
  logic signed [3:0]      delta;
  logic signed [3:0]      acc_sum;
  logic [4:0]             addr_q [4];
  logic [4:0]             addr_d [4];
  logic                   step_inc_q, step_inc_d;
  logic                   step_dec_q, step_dec_d;
  logic                   quad_err_q, quad_err_d;

  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], bus.rot_a};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], bus.rot_b};
  end

  assign cur_phase = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

  // Gray sequence 00->01->11->10 is forward; both bits flipping is illegal.
  always_comb begin
    delta      = '0;
    quad_err_d = 1'b0;
    phase_d    = cur_phase;
    case ({phase_q, cur_phase})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: delta = 4'sd1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: delta = -4'sd1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: quad_err_d = 1'b1;
      default: ;
    endcase
  end

  // clr overrides a completing detent so no pulse escapes with zeroed addresses.
  always_comb begin
    acc_sum    = acc_q + delta;
    acc_d      = acc_sum;
    addr_d     = addr_q;
    step_inc_d = 1'b0;
    step_dec_d = 1'b0;
    if (bus.clr) begin
      acc_d = '0;
      for (int i = 0; i < 4; i++) addr_d[i] = '0;
    end else if (acc_sum == DET_POS) begin
      acc_d              = '0;
      addr_d[bus.page]   = addr_q[bus.page] + 5'd1;
      step_inc_d         = 1'b1;
    end else if (acc_sum == DET_NEG) begin
      acc_d              = '0;
      addr_d[bus.page]   = addr_q[bus.page] - 5'd1;
      step_dec_d         = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sync_q   <= '0;
      b_sync_q   <= '0;
      phase_q    <= '0;
      acc_q      <= '0;
      step_inc_q <= 1'b0;
      step_dec_q <= 1'b0;
      quad_err_q <= 1'b0;
      for (int i = 0; i < 4; i++) addr_q[i] <= '0;
    end else begin
      a_sync_q   <= a_sync_d;
      b_sync_q   <= b_sync_d;
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      step_inc_q <= step_inc_d;
      step_dec_q <= step_dec_d;
      quad_err_q <= quad_err_d;
      for (int i = 0; i < 4; i++) addr_q[i] <= addr_d[i];
    end
  end

  assign bus.addr      = addr_q[bus.page];
  assign bus.disp_addr = {1'b0, bus.page, addr_q[bus.page]};
  assign bus.step_inc  = step_inc_q;
  assign bus.step_dec  = step_dec_q;
  assign bus.quad_err  = quad_err_q;

endmodule

// File: tb/tb_disp_addr_ctrl.sv
// Self-checking bench for disp_addr_ctrl: directed scenarios plus a random encoder walk,
// all checked cycle by cycle against a delay-line/position-arithmetic reference model.
module tb_disp_addr_ctrl;

  localparam int DETENT      = 4;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  disp_addr_ctrl_if bus ();

  disp_addr_ctrl #(.DETENT(DETENT), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   m_addr [4];
  int   m_acc;
  int   hist [$];
  logic exp_inc, exp_dec, exp_err;
  int   inc_seen, dec_seen, err_seen;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int gray_pos(input int ab);
    case (ab)
      0:       return 0;
      1:       return 1;
      3:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] pos_gray(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // The decoder sees the input sampled SYNC_STAGES edges earlier, compared with the one before it.
  task automatic modelReset();
    hist.delete();
    repeat (SYNC_STAGES + 1) hist.push_back(0);
    m_acc = 0;
    for (int i = 0; i < 4; i++) m_addr[i] = 0;
    exp_inc = 1'b0;
    exp_dec = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic modelEdge(input logic a, input logic b, input logic [1:0] pg, input logic c);
    int prev, cur, d;
    hist.push_back(int'({a, b}));
    prev = hist[hist.size() - 2 - SYNC_STAGES];
    cur  = hist[hist.size() - 1 - SYNC_STAGES];
    d = (gray_pos(cur) - gray_pos(prev) + 4) % 4;
    exp_inc = 1'b0;
    exp_dec = 1'b0;
    exp_err = (d == 2);
    if (d == 1) m_acc++;
    else if (d == 3) m_acc--;
    if (c) begin
      m_acc = 0;
      for (int i = 0; i < 4; i++) m_addr[i] = 0;
    end else if (m_acc == DETENT) begin
      m_acc = 0;
      m_addr[pg] = (m_addr[pg] + 1) % 32;
      exp_inc = 1'b1;
    end else if (m_acc == -DETENT) begin
      m_acc = 0;
      m_addr[pg] = (m_addr[pg] + 31) % 32;
      exp_dec = 1'b1;
    end
    if (hist.size() > SYNC_STAGES + 2) hist.delete(0);
  endtask

  task automatic checkAll();
    checkOutput("step_inc", 32'(bus.step_inc), 32'(exp_inc));
    checkOutput("step_dec", 32'(bus.step_dec), 32'(exp_dec));
    checkOutput("quad_err", 32'(bus.quad_err), 32'(exp_err));
    checkOutput("addr", 32'(bus.addr), 32'(m_addr[bus.page]));
    checkOutput("disp_addr", 32'(bus.disp_addr), 32'({1'b0, bus.page, 5'(m_addr[bus.page])}));
    checkOutput("pulse_excl", 32'(bus.step_inc & bus.step_dec), 32'd0);
    if (bus.step_inc) inc_seen++;
    if (bus.step_dec) dec_seen++;
    if (bus.quad_err) err_seen++;
  endtask

  task automatic applyStimulus(input logic a, input logic b, input logic [1:0] pg, input logic c);
    bus.rot_a = a;
    bus.rot_b = b;
    bus.page  = pg;
    bus.clr   = c;
    @(posedge clk);
    modelEdge(a, b, pg, c);
    #1;
    checkAll();
  endtask

  task automatic holdPhase(input logic [1:0] ab, input int cycles, input logic [1:0] pg);
    repeat (cycles) applyStimulus(ab[1], ab[0], pg, 1'b0);
  endtask

  task automatic detent(input bit fwd, input logic [1:0] pg, input int hold);
    if (fwd) begin
      holdPhase(2'b01, hold, pg);
      holdPhase(2'b11, hold, pg);
      holdPhase(2'b10, hold, pg);
      holdPhase(2'b00, hold, pg);
    end else begin
      holdPhase(2'b10, hold, pg);
      holdPhase(2'b11, hold, pg);
      holdPhase(2'b01, hold, pg);
      holdPhase(2'b00, hold, pg);
    end
  endtask

  task automatic clearCounts();
    inc_seen = 0;
    dec_seen = 0;
    err_seen = 0;
  endtask

  initial begin
    int p;
    logic [1:0] pg;
    logic [1:0] ab;
    bus.rot_a = 1'b1;
    bus.rot_b = 1'b1;
    bus.page  = 2'd3;
    bus.clr   = 1'b0;
    modelReset();
    clearCounts();

    // Reset state, with page decode still combinational.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_addr", 32'(bus.addr), 32'd0);
    checkOutput("rst_disp", 32'(bus.disp_addr), 32'h60);
    checkOutput("rst_inc", 32'(bus.step_inc), 32'd0);
    checkOutput("rst_dec", 32'(bus.step_dec), 32'd0);
    checkOutput("rst_err", 32'(bus.quad_err), 32'd0);

    // Release with inputs at 11: nothing on the first cycle, later a jump error.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b0);
    checkOutput("first_cycle_err", 32'(bus.quad_err), 32'd0);
    holdPhase(2'b00, SYNC_STAGES + 3, 2'd0);

    // One forward detent, phases held 3 cycles.
    clearCounts();
    detent(1'b1, 2'd0, 3);
    holdPhase(2'b00, SYNC_STAGES + 2, 2'd0);
    checkOutput("fwd_inc_count", 32'(inc_seen), 32'd1);
    checkOutput("fwd_addr", 32'(bus.addr), 32'd1);

    // Reverse detent on page 2 wraps 0 -> 31.
    clearCounts();
    detent(1'b0, 2'd2, 2);
    holdPhase(2'b00, SYNC_STAGES + 2, 2'd2);
    checkOutput("rev_dec_count", 32'(dec_seen), 32'd1);
    checkOutput("rev_addr", 32'(bus.addr), 32'd31);
    checkOutput("rev_disp", 32'(bus.disp_addr), 32'h5F);
    for (int i = 0; i < 4; i++) begin
      bus.page = 2'(i);
      #1;
      checkOutput("page_view", 32'(bus.addr), 32'(m_addr[i]));
    end

    // Half detent forward then back: accumulator returns to zero.
    clearCounts();
    holdPhase(2'b01, 2, 2'd0);
    holdPhase(2'b11, 2, 2'd0);
    holdPhase(2'b01, 2, 2'd0);
    holdPhase(2'b00, SYNC_STAGES + 2, 2'd0);
    checkOutput("revert_pulses", 32'(inc_seen + dec_seen), 32'd0);
    detent(1'b1, 2'd0, 1);
    holdPhase(2'b00, SYNC_STAGES + 2, 2'd0);
    checkOutput("revert_then_inc", 32'(inc_seen), 32'd1);
    checkOutput("revert_addr", 32'(bus.addr), 32'd2);

    // Illegal jump 00 -> 11 and back.
    clearCounts();
    holdPhase(2'b11, 2, 2'd0);
    holdPhase(2'b00, SYNC_STAGES + 3, 2'd0);
    checkOutput("jump_err_count", 32'(err_seen), 32'd2);
    checkOutput("jump_no_step", 32'(inc_seen + dec_seen), 32'd0);
    checkOutput("jump_addr", 32'(bus.addr), 32'd2);

    // Page 1 to 7, then clr on the edge that completes the next detent.
    for (int i = 0; i < 7; i++) detent(1'b1, 2'd1, 1);
    holdPhase(2'b00, SYNC_STAGES + 2, 2'd1);
    checkOutput("pre_clr_addr", 32'(bus.addr), 32'd7);
    clearCounts();
    holdPhase(2'b01, 1, 2'd1);
    holdPhase(2'b11, 1, 2'd1);
    holdPhase(2'b10, 1, 2'd1);
    holdPhase(2'b00, SYNC_STAGES, 2'd1);
    applyStimulus(1'b0, 1'b0, 2'd1, 1'b1);
    holdPhase(2'b00, 2, 2'd1);
    checkOutput("clr_no_inc", 32'(inc_seen), 32'd0);
    checkOutput("clr_addr", 32'(bus.addr), 32'd0);
    bus.page = 2'd0;
    #1;
    checkOutput("clr_page0", 32'(bus.addr), 32'd0);

    // Random encoder walk with page changes, rare jumps and rare clears.
    p  = 0;
    pg = 2'd0;
    for (int n = 0; n < 800; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 40) p = (p + 1) % 4;
      else if (r < 75) p = (p + 3) % 4;
      else if (r < 80) p = (p + 2) % 4;
      if ($urandom_range(0, 9) == 0) pg = 2'($urandom_range(0, 3));
      ab = pos_gray(p);
      applyStimulus(ab[1], ab[0], pg, ($urandom_range(0, 49) == 0));
    end
    holdPhase(pos_gray(p), SYNC_STAGES + 2, pg);
    holdPhase(2'b00, SYNC_STAGES + 3, 2'd0);

    // Asynchronous reset mid-detent discards the partial count.
    holdPhase(2'b01, 2, 2'd0);
    holdPhase(2'b11, SYNC_STAGES + 2, 2'd0);
    #2;
    rst = 1'b0;
    bus.rot_a = 1'b0;
    bus.rot_b = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      bus.page = 2'(i);
      #1;
      checkOutput("async_rst_addr", 32'(bus.addr), 32'd0);
    end
    checkOutput("async_rst_pulses", 32'(bus.step_inc | bus.step_dec | bus.quad_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    clearCounts();
    holdPhase(2'b00, SYNC_STAGES + 2, 2'd0);
    checkOutput("post_rst_quiet", 32'(inc_seen + dec_seen + err_seen), 32'd0);
    detent(1'b1, 2'd0, 2);
    holdPhase(2'b00, SYNC_STAGES + 2, 2'd0);
    checkOutput("post_rst_inc", 32'(inc_seen), 32'd1);
    checkOutput("post_rst_addr", 32'(bus.addr), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_addr_ctrl.md
DISP_ADDR_CTRL -- requirements
Module: disp_addr_ctrl

Interface
REQ-001 Parameter DETENT, default 4: valid quadrature transitions per address step; legal values 1, 2, 4.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on rot_a/rot_b; legal values 2..4.
REQ-003 clk  input  1  CPU clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rot_a  input  1  debounced encoder phase A, asynchronous to clk.
REQ-006 rot_b  input  1  debounced encoder phase B, asynchronous to clk.
REQ-007 page  input  2  display page select; selects the current address register.
REQ-008 clr  input  1  synchronous clear, active-high.
REQ-009 addr  output  5  address register of the currently selected page.
REQ-010 disp_addr  output  8  display address bus {1'b0, page, addr}.
REQ-011 step_inc  output  1  one-cycle pulse: an address increment was applied.
REQ-012 step_dec  output  1  one-cycle pulse: an address decrement was applied.
REQ-013 quad_err  output  1  one-cycle pulse: an illegal quadrature transition was seen.

Function
REQ-014 rot_a and rot_b shall each pass through SYNC_STAGES flops; only the last stage shall be decoded.
REQ-015 A phase register shall hold the previous synchronized {a,b}; the decoder shall compare it with the current synchronized {a,b} every cycle.
REQ-016 Forward sequence 00->01->11->10->00 shall add +1 to a signed accumulator; the reverse sequence shall add -1.
REQ-017 An unchanged phase shall leave the accumulator unchanged.
REQ-018 A two-bit phase change shall leave the accumulator unchanged, pulse quad_err, and update the phase register.
REQ-019 Accumulator reaching +DETENT: clear to 0; increment the selected page address mod 32; pulse step_inc.
REQ-020 Accumulator reaching -DETENT: clear to 0; decrement the selected page address mod 32; pulse step_dec.
REQ-021 The address update and its pulse shall occur on the same edge that registers the triggering phase.
REQ-022 Latency from a phase change at the rot inputs to step_inc/step_dec shall be SYNC_STAGES+1 rising edges.
REQ-023 Address wrap: 31 + 1 = 0; 0 - 1 = 31.
REQ-024 Four independent 5-bit address registers shall exist, one per page; non-selected registers shall hold their value.
REQ-025 addr and disp_addr shall be combinational from page and the register file; a page change shall be visible in the same cycle.
REQ-026 A step shall apply to the page value sampled at the same edge.
REQ-027 A direction reversal mid-detent shall count down the accumulator; no pulse shall fire until the accumulator reaches ±DETENT.
REQ-028 clr shall zero all four addresses and the accumulator; it shall suppress step pulses that cycle; it shall not affect the synchronizers or the phase register.
REQ-029 clr together with a completing detent: clr wins, no pulse, addresses 0.
REQ-030 step_inc and step_dec shall never be high together; each pulse shall last exactly one cycle.

Reset
REQ-031 While rst is low: addresses = 0, accumulator = 0, synchronizers and phase register = 00, all pulses = 0.
REQ-032 Reset assertion mid-detent shall discard the partial accumulation.
REQ-033 The first cycle after reset release shall not generate quad_err or a step, whatever the input levels.

Verification
REQ-034 DETENT=4, page=0: one full forward cycle 00->01->11->10->00, each phase held 3 cycles -> exactly one step_inc, SYNC_STAGES+1 edges after the final 00, addr 0->1.
REQ-035 page=2, addr2=0: one reverse detent -> step_dec, addr=31, disp_addr=8'h5F; pages 0, 1 and 3 unchanged.
REQ-036 Two forward steps (01, 11), then back (01, 00) -> no pulses, accumulator 0, addr unchanged.
REQ-037 Phase jump 00->11 -> quad_err for one cycle, no step, addr unchanged.
REQ-038 clr asserted on the edge completing a forward detent with addr=7 -> no step_inc, addr=0.
REQ-039 rst pulled low asynchronously after 2 forward transitions, then released with inputs at 00 -> all addresses 0, no pulses; the next full detent yields exactly one step_inc.
